// File: rtl/intr_controller.sv
// -----------------------------------------------------------------------------
// intr_controller
//
// Interrupt source side of the CPU INT handshake. Peripheral irq lines are
// edge-detected (0->1) into pending flags, qualified by a per-source enable
// mask, and the lowest-index eligible source is presented to the core as INT
// together with its ISR address. The core acknowledges entry with int_ack and
// signals end of service with int_eoi. Only one interrupt is in service at a
// time; there is no nesting.
//
// Optional build macro:
//   INTC_SYNC_EN  - irq_src passes through a 2-flop synchronizer (reset to all
//                   ones) before edge detection; adds two cycles of latency.
//                   Undefined: irq_src is assumed synchronous to clk.
//
// Parameters:
//   NUM_SRC     number of irq sources (1..32); index 0 = highest priority
//   VEC_BASE    ISR address of source 0
//   VEC_STRIDE  byte spacing between consecutive ISR addresses
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   irq_src     peripheral interrupt levels, rising edge = request
//   mask_we     write strobe for the enable mask
//   mask_wdata  new enable mask (1 = source enabled)
//   int_ack     core accepted INT (one-cycle pulse)
//   int_eoi     core finished the ISR (one-cycle pulse)
//   INT         registered interrupt request to the core
//   int_vec     ISR address = VEC_BASE + int_id * VEC_STRIDE (mod 2^32)
//   int_id      index of the source presented / in service
//   pending     pending flags, masked or not
//   in_service  high from accepted ack until eoi
// -----------------------------------------------------------------------------
module intr_controller #(
  parameter int unsigned NUM_SRC    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic               INT,
  output logic [31:0]        int_vec,
  output logic [4:0]         int_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               in_service
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t state, state_n;

  // ---------------------------------------------------------------------------
  // Optional input synchronizer
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] irq_s;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1;
  logic [NUM_SRC-1:0] sync_q2;

  // Reset to all ones so a line already high at reset release looks stable,
  // never like a fresh rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_s = sync_q2;
`else
  assign irq_s = irq_src;
`endif

  // ---------------------------------------------------------------------------
  // Edge detection and enable mask
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] irq_hist;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] mask;

  // History starts at all ones: a level held high through reset is not a request.
  // NOTE: sequential state is written with non-blocking (<=) assignments so every
  // flop samples pre-edge values regardless of the order blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_hist <= '1;
    end else begin
      irq_hist <= irq_s;
    end
  end

  assign rise = irq_s & ~irq_hist;

  // A mask write lands at the edge, so an ack in the same cycle still works on
  // the int_id chosen under the old mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Fixed-priority encoder: lowest set index of eligible wins
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] eligible;
  logic               any_eligible;
  logic [4:0]         winner;
  logic [31:0]        winner_vec;

  assign eligible     = pending & mask;
  assign any_eligible = |eligible;

  // Scanning from the top down lets the lowest index overwrite last.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = 5'(i);
      end
    end
  end

  // Plain 32-bit unsigned arithmetic; overflow wraps modulo 2^32.
  assign winner_vec = VEC_BASE + (32'(winner) * 32'(VEC_STRIDE));

  // ---------------------------------------------------------------------------
  // Handshake FSM: next-state and next-output logic
  // ---------------------------------------------------------------------------
  logic        int_n;
  logic        in_service_n;
  logic [4:0]  int_id_n;
  logic [31:0] int_vec_n;
  logic        ack_clr;

  // NOTE: every output of this block gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_n      = state;
    int_n        = INT;
    in_service_n = in_service;
    int_id_n     = int_id;
    int_vec_n    = int_vec;
    ack_clr      = 1'b0;

    case (state)
      S_IDLE: begin
        if (any_eligible) begin
          state_n   = S_ASSERT;
          int_n     = 1'b1;
          int_id_n  = winner;
          int_vec_n = winner_vec;
        end
      end

      S_ASSERT: begin
        if (int_ack) begin
          // Entry accepted: id/vec frozen at the value the core just saw.
          state_n      = S_SERVICE;
          int_n        = 1'b0;
          in_service_n = 1'b1;
          ack_clr      = 1'b1;
        end else if (!any_eligible) begin
          // Request withdrawn (e.g. mask cleared) before the core took it.
          state_n = S_IDLE;
          int_n   = 1'b0;
        end else begin
          // Track the current winner so a higher-priority arrival preempts.
          int_id_n  = winner;
          int_vec_n = winner_vec;
        end
      end

      S_SERVICE: begin
        if (int_eoi) begin
          state_n      = S_IDLE;
          in_service_n = 1'b0;
        end
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pending flags: clear the acknowledged source; a same-cycle new edge wins
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] pending_n;

  // Decoded by comparison rather than indexing with the 5-bit id, which may be
  // wider than the pending vector needs.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      clr_vec[i] = ack_clr && (int_id == 5'(i));
    end
  end

  assign pending_n = (pending & ~clr_vec) | rise;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      INT        <= 1'b0;
      in_service <= 1'b0;
      int_id     <= '0;
      int_vec    <= VEC_BASE;
      pending    <= '0;
    end else begin
      state      <= state_n;
      INT        <= int_n;
      in_service <= in_service_n;
      int_id     <= int_id_n;
      int_vec    <= int_vec_n;
      pending    <= pending_n;
    end
  end

endmodule
